// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. Converts a
//               WIDTH-bit value (unsigned or two's complement) into DIGITS
//               packed BCD nibbles plus a sign flag. The result is held
//               stable between conversions for the display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      value_in,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_sr_w  = c_bcd_w + WIDTH;
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_sr_w-1:0]    r_sr;        // {bcd digits, remaining magnitude bits}
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_sign;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_neg;
    logic [c_bcd_w-1:0]   r_bcd_out;

    logic                 w_sign_in;
    logic [WIDTH-1:0]     w_mag_in;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_sr_w-1:0]    w_cat;
    logic [c_sr_w-1:0]    w_shift;

    // Sign/magnitude split at capture; 0x80 in signed mode yields magnitude 128.
    assign w_sign_in = signed_mode & value_in[WIDTH-1];
    assign w_mag_in  = w_sign_in ? (~value_in + WIDTH'(1)) : value_in;

    // Add-3 correction on every nibble >= 5, all from pre-shift values.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_sr[WIDTH + 4*d +: 4] >= 4'd5)
                               ? (r_sr[WIDTH + 4*d +: 4] + 4'd3)
                               : r_sr[WIDTH + 4*d +: 4];
    end

    assign w_cat   = {w_adj, r_sr[WIDTH-1:0]};
    assign w_shift = w_cat << 1;

    // Control FSM with conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
            r_bcd_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr    <= {{c_bcd_w{1'b0}}, w_mag_in};
                        r_sign  <= w_sign_in;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr    <= w_shift;
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_cnt_w'(WIDTH - 1)) begin
                        // Final shift: publish the result as DONE is entered.
                        r_bcd_out <= w_shift[c_sr_w-1:WIDTH];
                        r_neg     <= r_sign;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign neg     = r_neg;
    assign bcd_out = r_bcd_out;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. An arithmetic model
//               tracks expected busy/done/neg/bcd_out every cycle; directed
//               tests pin latency and literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  value_in = 8'h00;
    logic        busy;
    logic        done;
    logic        neg;
    logic [11:0] bcd_out;

    int n_pass  = 0;
    int n_total = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .value_in    (value_in),
        .busy        (busy),
        .done        (done),
        .neg         (neg),
        .bcd_out     (bcd_out)
    );

    always #5 clk = ~clk;

    // Expected BCD from plain decimal arithmetic on the magnitude.
    function automatic logic [11:0] ref_bcd(input logic [7:0] v, input logic s);
        int m;
        m = (s && v[7]) ? (256 - int'(v)) : int'(v);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_neg(input logic [7:0] v, input logic s);
        return s && v[7];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Cycle model: a conversion occupies WIDTH+1 busy cycles, the last being done.
    int          m_left;
    logic [11:0] m_bcd, m_pb;
    logic        m_neg, m_pn;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_bcd  <= '0;
            m_neg  <= 1'b0;
            m_pb   <= '0;
            m_pn   <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= WIDTH + 1;
                m_pb   <= ref_bcd(value_in, signed_mode);
                m_pn   <= ref_neg(value_in, signed_mode);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_bcd <= m_pb;
                m_neg <= m_pn;
            end
        end
        m_valid <= 1'b1;
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_done", 32'(done), 32'(m_left == 1));
            chk("model_neg",  32'(neg),  32'(m_neg));
            chk("model_bcd",  32'(bcd_out), 32'(m_bcd));
        end
    end

    // One conversion; returns the cycle in which done was seen (-1 on timeout).
    task automatic convert(input logic [7:0] v, input logic s, output int lat);
        @(negedge clk);
        start       = 1'b1;
        value_in    = v;
        signed_mode = s;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start       = 1'b0;
            value_in    = ~v;          // must not disturb the captured value
            signed_mode = ~s;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("done_timeout", 32'(lat != -1), 32'd1);
    endtask

    initial begin
        int lat;
        int ndone;
        int lastk;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd",  32'(bcd_out), 32'd0);
        chk("reset_neg",  32'(neg), 32'd0);
        reset = 1'b0;

        // 1. Unsigned zero
        convert(8'h00, 1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_bcd", 32'(bcd_out), 32'h000);
        chk("t1_neg", 32'(neg), 32'd0);

        // 2. Unsigned 0xFF, busy window
        convert(8'hFF, 1'b0, lat);
        chk("t2_latency", 32'(lat), 32'd9);
        chk("t2_bcd", 32'(bcd_out), 32'h255);
        chk("t2_busy9", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t2_busy10", 32'(busy), 32'd0);

        // 3. Signed boundaries
        convert(8'h80, 1'b1, lat);
        chk("t3a_bcd", 32'(bcd_out), 32'h128);
        chk("t3a_neg", 32'(neg), 32'd1);
        convert(8'hFF, 1'b1, lat);
        chk("t3b_bcd", 32'(bcd_out), 32'h001);
        chk("t3b_neg", 32'(neg), 32'd1);
        convert(8'h7F, 1'b1, lat);
        chk("t3c_bcd", 32'(bcd_out), 32'h127);
        chk("t3c_neg", 32'(neg), 32'd0);
        convert(8'h00, 1'b1, lat);
        chk("t3d_neg", 32'(neg), 32'd0);

        // 4. Start while busy is ignored; restart after done
        @(negedge clk);
        start = 1'b1; value_in = 8'h0C; signed_mode = 1'b0;
        ndone = 0; lastk = -1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) begin ndone++; lastk = k; end
            start    = (k == 4);
            value_in = (k == 4) ? 8'h63 : 8'h0C;
        end
        chk("t4_ndone", 32'(ndone), 32'd1);
        chk("t4_lastk", 32'(lastk), 32'd9);
        chk("t4_bcd", 32'(bcd_out), 32'h012);
        @(negedge clk);                // cycle 10
        start = 1'b1; value_in = 8'h63;
        lastk = -1;
        for (int k = 11; k <= 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lastk = k; break; end
        end
        chk("t4_restart_cycle", 32'(lastk), 32'd19);
        chk("t4_restart_bcd", 32'(bcd_out), 32'h099);

        // 5. Reset aborts a running conversion
        convert(8'hC8, 1'b0, lat);
        chk("t5_bcd", 32'(bcd_out), 32'h200);
        @(negedge clk);
        start = 1'b1; value_in = 8'h05; signed_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (k == 5);
        end
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_bcd0", 32'(bcd_out), 32'd0);
        chk("t5_neg0", 32'(neg), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);

        // Start held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1; value_in = 8'h2A; signed_mode = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_bcd", 32'(bcd_out), 32'h042);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // 6. Full sweep in both modes
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                convert(8'(v), 1'(s), lat);
                chk("sweep_lat", 32'(lat), 32'd9);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
